// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
`timescale 1ns/1ps
package keypad_pkg;

  // Default matrix geometry for the calculator keypad.
  localparam int KEY_ROW_DEF = 4;
  localparam int KEY_COL_DEF = 4;

  // Widest line vector the decoder helper accepts, and its index width.
  localparam int MAX_LINES = 16;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_REPORT,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic             valid;  // exactly one bit of the input was set
    logic [IDX_W-1:0] idx;    // position of that bit
  } onehot_idx_t;

  // Binary index of a one-hot vector. valid is low for an all-zero vector
  // and for any vector with two or more bits set (ghosting on the matrix).
  function automatic onehot_idx_t onehot_to_idx(input logic [MAX_LINES-1:0] vec);
    onehot_idx_t res;
    int unsigned n;
    res = '0;
    n   = 0;
    for (int i = 0; i < MAX_LINES; i++) begin
      if (vec[i]) begin
        res.idx = IDX_W'(i);
        n++;
      end
    end
    res.valid = (n == 1);
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin/decoder-side bundle of the keypad scanner.
// Latency: n/a (wiring only).
// Backpressure: none; key_in is a fire-and-forget strobe.
`timescale 1ns/1ps
interface keypad_scanner_if #(
  parameter int KEY_ROW = keypad_pkg::KEY_ROW_DEF,
  parameter int KEY_COL = keypad_pkg::KEY_COL_DEF
);

  logic [KEY_ROW-1:0] row_sense;  // raw row lines, asynchronous to clk
  logic [KEY_COL-1:0] col_drv;    // one-hot column strobe
  logic               key_in;     // one-cycle debounced key report
  logic [KEY_ROW-1:0] row;        // binary row index of reported key
  logic [KEY_COL-1:0] col;        // binary column index of reported key

  // The scanner drives the columns and the report, and senses the rows.
  modport master (
    input  row_sense,
    output col_drv, key_in, row, col
  );

  // The keypad/decoder side sees the mirror image.
  modport slave (
    output row_sense,
    input  col_drv, key_in, row, col
  );

endinterface

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for quasi-static multi-bit inputs (keypad rows).
// Latency: 2 clk cycles from input to q.
// Backpressure: none.
`timescale 1ns/1ps
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; bits are treated independently, which is fine
  // because row lines settle long before the scanner samples them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one column at a time, debounces one key, strobes key_in.
// Latency: key_in rises DEBOUNCE*SCAN_DIV cycles after the key's column is first driven.
// Backpressure: none; a held key is reported once and must be released before the next report.
`timescale 1ns/1ps
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int KEY_ROW  = KEY_ROW_DEF,
  parameter int KEY_COL  = KEY_COL_DEF,
  parameter int SCAN_DIV = 16,  // dwell per column sample; >= 4 so rs settles
  parameter int DEBOUNCE = 4    // identical samples needed for press and release
) (
  input  logic             clk,
  input  logic             rst_n,
  keypad_scanner_if.master kp
);

  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);
  localparam int CIDX_W = (KEY_COL > 1) ? $clog2(KEY_COL) : 1;

  // Synchronized row lines; every decision below is taken on rs.
  logic [KEY_ROW-1:0] rs;

  // Dwell counter and the sample tick it produces.
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;

  // Scan state.
  state_t             state;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   rel_cnt;
  logic [CNT_W-1:0]   hit_nxt;
  logic [CNT_W-1:0]   rel_nxt;

  // Column rotator: one-hot drive plus its binary index kept in lock-step.
  logic [KEY_COL-1:0] col_drv_q;
  logic [KEY_COL-1:0] col_drv_nxt;
  logic [CIDX_W-1:0]  col_idx;
  logic [CIDX_W-1:0]  col_idx_nxt;

  // Candidate key captured on the first one-hot sample.
  logic [KEY_ROW-1:0] row_lat;
  logic [IDX_W-1:0]   row_idx_lat;
  logic [CIDX_W-1:0]  col_idx_lat;

  // Registered outputs.
  logic               key_in_q;
  logic [KEY_ROW-1:0] row_q;
  logic [KEY_COL-1:0] col_q;

  // Row decode; rows beyond MAX_LINES are not supported by the helper.
  onehot_idx_t        rs_dec;

  sync_2ff #(
    .WIDTH (KEY_ROW)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (kp.row_sense),
    .q     (rs)
  );

  assign rs_dec      = onehot_to_idx(MAX_LINES'(rs));
  assign tick        = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign hit_nxt     = hit_cnt + CNT_W'(1);
  assign rel_nxt     = rel_cnt + CNT_W'(1);
  assign col_drv_nxt = {col_drv_q[KEY_COL-2:0], col_drv_q[KEY_COL-1]};
  assign col_idx_nxt = (col_idx == CIDX_W'(KEY_COL - 1)) ? '0 : col_idx + CIDX_W'(1);

  // Free-running dwell counter. Columns only ever move on the cycle after a
  // tick, which is exactly when this wraps, so it restarts with every new column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Scan / debounce / report / hold sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SCAN;
      col_drv_q   <= KEY_COL'(1);
      col_idx     <= '0;
      hit_cnt     <= '0;
      rel_cnt     <= '0;
      row_lat     <= '0;
      row_idx_lat <= '0;
      col_idx_lat <= '0;
      key_in_q    <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      key_in_q <= 1'b0;
      case (state)
        // Look for exactly one active row on the driven column; anything else
        // (idle or ghosting) moves the scan on.
        ST_SCAN: begin
          if (tick) begin
            if (rs_dec.valid) begin
              row_lat     <= rs;
              row_idx_lat <= rs_dec.idx;
              col_idx_lat <= col_idx;
              hit_cnt     <= CNT_W'(1);
              if (DEBOUNCE <= 1) begin
                state    <= ST_REPORT;
                key_in_q <= 1'b1;
                row_q    <= KEY_ROW'(rs_dec.idx);
                col_q    <= KEY_COL'(col_idx);
              end else begin
                state <= ST_DEBOUNCE;
              end
            end else begin
              col_drv_q <= col_drv_nxt;
              col_idx   <= col_idx_nxt;
            end
          end
        end

        // Column held; the same single row must repeat on every sample.
        // The report is registered on the same edge that enters REPORT.
        ST_DEBOUNCE: begin
          if (tick) begin
            if (rs == row_lat) begin
              hit_cnt <= hit_nxt;
              if (hit_nxt == CNT_W'(DEBOUNCE)) begin
                state    <= ST_REPORT;
                key_in_q <= 1'b1;
                row_q    <= KEY_ROW'(row_idx_lat);
                col_q    <= KEY_COL'(col_idx_lat);
              end
            end else begin
              state     <= ST_SCAN;
              hit_cnt   <= '0;
              col_drv_q <= col_drv_nxt;
              col_idx   <= col_idx_nxt;
            end
          end
        end

        // key_in is high for exactly this one cycle.
        ST_REPORT: begin
          hit_cnt <= '0;
          rel_cnt <= '0;
          state   <= ST_HOLD;
        end

        // Wait for DEBOUNCE consecutive all-clear samples; any activity
        // restarts the count so a held key is never reported twice.
        ST_HOLD: begin
          if (tick) begin
            if (rs == '0) begin
              if (rel_nxt == CNT_W'(DEBOUNCE)) begin
                state     <= ST_SCAN;
                rel_cnt   <= '0;
                col_drv_q <= col_drv_nxt;
                col_idx   <= col_idx_nxt;
              end else begin
                rel_cnt <= rel_nxt;
              end
            end else begin
              rel_cnt <= '0;
            end
          end
        end

        default: begin
          state <= ST_SCAN;
        end
      endcase
    end
  end

  assign kp.col_drv = col_drv_q;
  assign kp.key_in  = key_in_q;
  assign kp.row     = row_q;
  assign kp.col     = col_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a column-aware keypad model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_keypad_scanner;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;

  // Keypad model: key_rows appear on the row lines only while key_col_oh is driven.
  logic [3:0] key_rows   = 4'b0000;
  logic [3:0] key_col_oh = 4'b0000;

  int errors = 0;
  int checks = 0;

  int         cyc         = 0;
  int         pulse_total = 0;
  int         pulse_cyc   = 0;
  int         dbl_pulse   = 0;
  logic [3:0] last_row    = 4'd0;
  logic [3:0] last_col    = 4'd0;
  logic       prev_key    = 1'b0;

  keypad_scanner_if #(.KEY_ROW(4), .KEY_COL(4)) kp ();

  keypad_scanner #(
    .KEY_ROW  (4),
    .KEY_COL  (4),
    .SCAN_DIV (16),
    .DEBOUNCE (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  assign kp.row_sense = (kp.col_drv == key_col_oh) ? key_rows : 4'b0000;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (kp.key_in) begin
      pulse_total <= pulse_total + 1;
      pulse_cyc   <= cyc;
      last_row    <= kp.row;
      last_col    <= kp.col;
      if (prev_key) dbl_pulse <= dbl_pulse + 1;
    end
    prev_key <= kp.key_in;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_col(input logic [3:0] oh, input int limit, output bit found);
    found = (kp.col_drv === oh);
    for (int i = 0; i < limit && !found; i++) begin
      step(1);
      found = (kp.col_drv === oh);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(40);
    rst_n = 1'b0;
    #1;
    checks++; if (kp.col_drv !== 4'b0001) begin errors++; $display("FAIL reset_col_drv: got %b want 0001", kp.col_drv); end
    checks++; if (kp.key_in !== 1'b0) begin errors++; $display("FAIL reset_key_in: got %b want 0", kp.key_in); end
    checks++; if (kp.row !== 4'd0) begin errors++; $display("FAIL reset_row: got %0d want 0", kp.row); end
    checks++; if (kp.col !== 4'd0) begin errors++; $display("FAIL reset_col: got %0d want 0", kp.col); end
    step(3);
    rst_n = 1'b1;
    step(15);
    checks++; if (kp.col_drv !== 4'b0001) begin errors++; $display("FAIL reset_dwell15: got %b want 0001", kp.col_drv); end
    step(1);
    checks++; if (kp.col_drv !== 4'b0010) begin errors++; $display("FAIL reset_dwell16: got %b want 0010", kp.col_drv); end
    step(16);
    checks++; if (kp.col_drv !== 4'b0100) begin errors++; $display("FAIL idle_scan_c2: got %b want 0100", kp.col_drv); end
    step(16);
    checks++; if (kp.col_drv !== 4'b1000) begin errors++; $display("FAIL idle_scan_c3: got %b want 1000", kp.col_drv); end
    step(16);
    checks++; if (kp.col_drv !== 4'b0001) begin errors++; $display("FAIL idle_scan_wrap: got %b want 0001", kp.col_drv); end
  endtask

  task automatic test_clean_press();
    bit found;
    int t0;
    int p0;
    p0 = pulse_total;
    key_rows   = 4'b0100;
    key_col_oh = 4'b0010;
    wait_col(4'b0010, 100, found);
    t0 = cyc;
    checks++; if (!found) begin errors++; $display("FAIL press_col1_seen: got %b want 0010", kp.col_drv); end
    step(500);
    checks++; if (pulse_total - p0 != 1) begin errors++; $display("FAIL press_pulse_count: got %0d want 1", pulse_total - p0); end
    checks++; if (pulse_cyc - t0 != 64) begin errors++; $display("FAIL press_latency: got %0d want 64", pulse_cyc - t0); end
    checks++; if (last_row !== 4'd2) begin errors++; $display("FAIL press_row: got %0d want 2", last_row); end
    checks++; if (last_col !== 4'd1) begin errors++; $display("FAIL press_col: got %0d want 1", last_col); end
    checks++; if (kp.row !== 4'd2 || kp.col !== 4'd1) begin errors++; $display("FAIL press_hold_rowcol: got %0d/%0d want 2/1", kp.row, kp.col); end
    checks++; if (kp.col_drv !== 4'b0010) begin errors++; $display("FAIL press_col_held: got %b want 0010", kp.col_drv); end
    key_rows = 4'b0000;
    wait_col(4'b0100, 200, found);
    checks++; if (!found) begin errors++; $display("FAIL release_advance: got %b want 0100", kp.col_drv); end
  endtask

  task automatic test_release_repress();
    bit found;
    bit got;
    int t0;
    int p0;
    p0 = pulse_total;
    key_rows   = 4'b1000;
    key_col_oh = 4'b1000;
    wait_col(4'b1000, 100, found);
    t0 = cyc;
    checks++; if (!found) begin errors++; $display("FAIL repress_col3_seen: got %b want 1000", kp.col_drv); end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step(1);
      got = kp.key_in;
    end
    checks++; if (!got) begin errors++; $display("FAIL repress_pulse: got none want key_in within 100 cycles"); end
    checks++; if (cyc - t0 != 64) begin errors++; $display("FAIL repress_latency: got %0d want 64", cyc - t0); end
    checks++; if (kp.row !== 4'd3 || kp.col !== 4'd3) begin errors++; $display("FAIL repress_rowcol: got %0d/%0d want 3/3", kp.row, kp.col); end
    // Release across exactly three samples, then press again.
    step(20);
    key_rows = 4'b0000;
    step(48);
    key_rows = 4'b1000;
    step(200);
    checks++; if (pulse_total - p0 != 1) begin errors++; $display("FAIL short_release_pulses: got %0d want 1", pulse_total - p0); end
    checks++; if (kp.col_drv !== 4'b1000) begin errors++; $display("FAIL short_release_col: got %b want 1000", kp.col_drv); end
    key_rows = 4'b0000;
    wait_col(4'b0001, 200, found);
    checks++; if (!found) begin errors++; $display("FAIL hold_release_wrap: got %b want 0001", kp.col_drv); end
  endtask

  task automatic test_bounce();
    bit found;
    int p0;
    p0 = pulse_total;
    key_rows   = 4'b0001;
    key_col_oh = 4'b0100;
    wait_col(4'b0100, 100, found);
    checks++; if (!found) begin errors++; $display("FAIL bounce_col2_seen: got %b want 0100", kp.col_drv); end
    step(36);
    key_rows = 4'b0000;
    step(11);
    checks++; if (kp.col_drv !== 4'b0100) begin errors++; $display("FAIL bounce_col_before: got %b want 0100", kp.col_drv); end
    step(1);
    checks++; if (kp.col_drv !== 4'b1000) begin errors++; $display("FAIL bounce_resume: got %b want 1000", kp.col_drv); end
    step(40);
    checks++; if (pulse_total - p0 != 0) begin errors++; $display("FAIL bounce_pulses: got %0d want 0", pulse_total - p0); end
  endtask

  task automatic test_ghost();
    bit found;
    int p0;
    wait_col(4'b0001, 100, found);
    checks++; if (!found) begin errors++; $display("FAIL ghost_col0_seen: got %b want 0001", kp.col_drv); end
    p0 = pulse_total;
    key_rows   = 4'b1010;
    key_col_oh = 4'b1000;
    wait_col(4'b1000, 100, found);
    checks++; if (!found) begin errors++; $display("FAIL ghost_col3_seen: got %b want 1000", kp.col_drv); end
    step(15);
    checks++; if (kp.col_drv !== 4'b1000) begin errors++; $display("FAIL ghost_col_dwell: got %b want 1000", kp.col_drv); end
    step(1);
    checks++; if (kp.col_drv !== 4'b0001) begin errors++; $display("FAIL ghost_wrap: got %b want 0001", kp.col_drv); end
    step(100);
    checks++; if (pulse_total - p0 != 0) begin errors++; $display("FAIL ghost_pulses: got %0d want 0", pulse_total - p0); end
    key_rows = 4'b0000;
  endtask

  task automatic test_reset_in_debounce();
    bit found;
    int p0;
    wait_col(4'b0010, 100, found);
    checks++; if (!found) begin errors++; $display("FAIL rstdb_col1_seen: got %b want 0010", kp.col_drv); end
    key_rows   = 4'b0010;
    key_col_oh = 4'b0001;
    p0 = pulse_total;
    wait_col(4'b0001, 100, found);
    checks++; if (!found) begin errors++; $display("FAIL rstdb_col0_seen: got %b want 0001", kp.col_drv); end
    step(52);
    rst_n = 1'b0;
    #1;
    checks++; if (kp.col_drv !== 4'b0001) begin errors++; $display("FAIL rstdb_col_drv: got %b want 0001", kp.col_drv); end
    checks++; if (kp.key_in !== 1'b0) begin errors++; $display("FAIL rstdb_key_in: got %b want 0", kp.key_in); end
    checks++; if (kp.row !== 4'd0) begin errors++; $display("FAIL rstdb_row: got %0d want 0", kp.row); end
    checks++; if (kp.col !== 4'd0) begin errors++; $display("FAIL rstdb_col: got %0d want 0", kp.col); end
    step(3);
    rst_n = 1'b1;
    step(63);
    checks++; if (kp.key_in !== 1'b0 || pulse_total != p0) begin errors++; $display("FAIL rstdb_early: got key_in=%b pulses=%0d want 0/0", kp.key_in, pulse_total - p0); end
    step(1);
    checks++; if (kp.key_in !== 1'b1) begin errors++; $display("FAIL rstdb_repress_pulse: got %b want 1", kp.key_in); end
    checks++; if (kp.row !== 4'd1 || kp.col !== 4'd0) begin errors++; $display("FAIL rstdb_rowcol: got %0d/%0d want 1/0", kp.row, kp.col); end
    step(1);
    checks++; if (kp.key_in !== 1'b0) begin errors++; $display("FAIL rstdb_pulse_width: got %b want 0", kp.key_in); end
    key_rows = 4'b0000;
  endtask

  task automatic test_back_to_back();
    step(20);
    checks++; if (dbl_pulse != 0) begin errors++; $display("FAIL back_to_back: got %0d adjacent key_in cycles want 0", dbl_pulse); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release_repress();
    test_bounce();
    test_ghost();
    test_reset_in_debounce();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
